// File: rtl/dmem_access.sv
// dmem_access: MEM-stage load/store unit. It turns one decoded load/store into a
// single SRAM-like bus transaction with byte strobes and lane-placed write data,
// and stalls the pipeline until that transaction completes. Write-back receives
// the raw aligned read word plus the original virtual address, and does its own
// byte/half extraction and LWL/LWR merging. Misaligned half/word accesses raise
// an address error and never reach the bus.
module dmem_access (
  input  logic        clk,
  input  logic        resetn,
  input  logic        en,
  input  logic        ld,
  input  logic        st,
  input  logic [2:0]  ls_type,
  input  logic [31:0] vaddr,
  input  logic [31:0] st_data,
  input  logic        adv,
  input  logic        flush,
  output logic        req,
  output logic        wr,
  output logic [1:0]  size,
  output logic [31:0] addr,
  output logic [3:0]  wstrb,
  output logic [31:0] wdata,
  input  logic        addr_ok,
  input  logic        data_ok,
  input  logic [31:0] rdata,
  output logic [31:0] m_vaddr,
  output logic [31:0] m_rdata,
  output logic        exc_adel,
  output logic        exc_ades,
  output logic        stallreq
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_DONE,
    S_DRAIN
  } state_t;

  state_t      r_state;
  logic        r_req;
  logic        r_wr;
  logic [1:0]  r_size;
  logic [31:0] r_addr;
  logic [3:0]  r_wstrb;
  logic [31:0] r_wdata;
  logic [31:0] r_mVaddr;
  logic [31:0] r_mRdata;

  logic [1:0]  w_a;
  logic        w_misaligned;
  logic        w_accept;
  logic [3:0]  w_wstrb;
  logic [31:0] w_wdata;
  logic [1:0]  w_size;

  assign w_a = vaddr[1:0];

  // Halves need an even address; words (and the 5-7 aliases) need a word-aligned one
  always_comb begin
    w_misaligned = 1'b0;
    case (ls_type)
      3'd0, 3'd3, 3'd4: w_misaligned = 1'b0;
      3'd1:             w_misaligned = w_a[0];
      default:          w_misaligned = (w_a != 2'b00);
    endcase
  end

  // Byte strobes, lane-placed store data and transfer size for the current instruction
  always_comb begin
    w_wstrb = 4'b1111;
    w_wdata = st_data;
    w_size  = 2'd2;
    case (ls_type)
      3'd0: begin
        w_size  = 2'd0;
        w_wdata = {4{st_data[7:0]}};
        case (w_a)
          2'd0:    w_wstrb = 4'b0001;
          2'd1:    w_wstrb = 4'b0010;
          2'd2:    w_wstrb = 4'b0100;
          default: w_wstrb = 4'b1000;
        endcase
      end
      3'd1: begin
        w_size  = 2'd1;
        w_wdata = {2{st_data[15:0]}};
        w_wstrb = w_a[1] ? 4'b1100 : 4'b0011;
      end
      3'd3: begin
        case (w_a)
          2'd0: begin
            w_wstrb = 4'b0001;
            w_wdata = {24'b0, st_data[31:24]};
          end
          2'd1: begin
            w_wstrb = 4'b0011;
            w_wdata = {16'b0, st_data[31:16]};
          end
          2'd2: begin
            w_wstrb = 4'b0111;
            w_wdata = {8'b0, st_data[31:8]};
          end
          default: begin
            w_wstrb = 4'b1111;
            w_wdata = st_data;
          end
        endcase
      end
      3'd4: begin
        case (w_a)
          2'd0: begin
            w_wstrb = 4'b1111;
            w_wdata = st_data;
          end
          2'd1: begin
            w_wstrb = 4'b1110;
            w_wdata = {st_data[23:0], 8'b0};
          end
          2'd2: begin
            w_wstrb = 4'b1100;
            w_wdata = {st_data[15:0], 16'b0};
          end
          default: begin
            w_wstrb = 4'b1000;
            w_wdata = {st_data[7:0], 24'b0};
          end
        endcase
      end
      default: begin
        w_wstrb = 4'b1111;
        w_wdata = st_data;
        w_size  = 2'd2;
      end
    endcase
  end

  assign w_accept = (r_state == S_IDLE) & en & (ld | st) & ~w_misaligned & ~flush;

  assign exc_adel = en & ld & w_misaligned;
  assign exc_ades = en & st & w_misaligned;
  assign stallreq = w_accept | (r_state == S_ADDR) | (r_state == S_DATA) | (r_state == S_DRAIN);

  assign req     = r_req;
  assign wr      = r_wr;
  assign size    = r_size;
  assign addr    = r_addr;
  assign wstrb   = r_wstrb;
  assign wdata   = r_wdata;
  assign m_vaddr = r_mVaddr;
  assign m_rdata = r_mRdata;

  // Run one bus transaction per accepted instruction, honour flushes, and hold the result for write-back
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_req    <= 1'b0;
      r_wr     <= 1'b0;
      r_size   <= 2'd0;
      r_addr   <= 32'd0;
      r_wstrb  <= 4'd0;
      r_wdata  <= 32'd0;
      r_mVaddr <= 32'd0;
      r_mRdata <= 32'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr   <= {vaddr[31:2], 2'b00};
            r_wr     <= st;
            r_size   <= w_size;
            r_wstrb  <= st ? w_wstrb : 4'b0000;
            r_wdata  <= w_wdata;
            r_mVaddr <= vaddr;
            r_req    <= 1'b1;
            r_state  <= S_ADDR;
          end
        end
        S_ADDR: begin
          if (addr_ok) begin
            r_req   <= 1'b0;
            r_state <= flush ? S_DRAIN : S_DATA;
          end else if (flush) begin
            r_req   <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        S_DATA: begin
          if (data_ok) begin
            if (flush) begin
              r_state <= S_IDLE;
            end else begin
              if (!r_wr) begin
                r_mRdata <= rdata;
              end
              r_state <= S_DONE;
            end
          end else if (flush) begin
            r_state <= S_DRAIN;
          end
        end
        S_DONE: begin
          if (adv || flush) begin
            r_state <= S_IDLE;
          end
        end
        S_DRAIN: begin
          if (data_ok) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_access.sv
// tb_dmem_access: scripted load/store transactions (directed, then random)
// against dmem_access. Each transaction script knows which bus phase it is in
// and publishes the outputs that phase must show; one negedge process compares.
module tb_dmem_access;

  logic        clk;
  logic        resetn;
  logic        en;
  logic        ld;
  logic        st;
  logic [2:0]  ls_type;
  logic [31:0] vaddr;
  logic [31:0] st_data;
  logic        adv;
  logic        flush;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [3:0]  wstrb;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;
  logic [31:0] m_vaddr;
  logic [31:0] m_rdata;
  logic        exc_adel;
  logic        exc_ades;
  logic        stallreq;

  logic        cmpOn;
  logic        expReq;
  logic        expStall;
  logic        expWr;
  logic [1:0]  expSize;
  logic [31:0] expAddr;
  logic [3:0]  expStrb;
  logic [31:0] expWdata;
  logic [31:0] expMVaddr;
  logic [31:0] expMRdata;

  int passCount;
  int checkCount;

  dmem_access dut (
    .clk      (clk),
    .resetn   (resetn),
    .en       (en),
    .ld       (ld),
    .st       (st),
    .ls_type  (ls_type),
    .vaddr    (vaddr),
    .st_data  (st_data),
    .adv      (adv),
    .flush    (flush),
    .req      (req),
    .wr       (wr),
    .size     (size),
    .addr     (addr),
    .wstrb    (wstrb),
    .wdata    (wdata),
    .addr_ok  (addr_ok),
    .data_ok  (data_ok),
    .rdata    (rdata),
    .m_vaddr  (m_vaddr),
    .m_rdata  (m_rdata),
    .exc_adel (exc_adel),
    .exc_ades (exc_ades),
    .stallreq (stallreq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checkCount++;
    if (act !== exp) begin
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end else begin
      passCount++;
    end
  endtask

  // Address-error rule: halves must be even, words and the 5-7 aliases must be word aligned
  function automatic logic misal(input logic [2:0] ty, input logic [1:0] a);
    return ((ty == 3'd1) && a[0]) || (((ty == 3'd2) || (ty > 3'd4)) && (a != 2'd0));
  endfunction

  // Lane placement written as shifts of the register value
  function automatic void busModel(input logic [2:0] ty, input logic [1:0] a2, input logic [31:0] rt,
                                   output logic [3:0] strb, output logic [31:0] wd, output logic [1:0] sz);
    int a;
    a = int'(a2);
    case (ty)
      3'd0: begin
        sz = 2'd0;
        strb = 4'(1 << a);
        wd = {4{rt[7:0]}};
      end
      3'd1: begin
        sz = 2'd1;
        strb = 4'(3 << a);
        wd = {2{rt[15:0]}};
      end
      3'd3: begin
        sz = 2'd2;
        strb = 4'(15 >> (3 - a));
        wd = rt >> (8 * (3 - a));
      end
      3'd4: begin
        sz = 2'd2;
        strb = 4'(15 << a);
        wd = rt << (8 * a);
      end
      default: begin
        sz = 2'd2;
        strb = 4'b1111;
        wd = rt;
      end
    endcase
  endfunction

  // Every cycle: compare the published phase expectations against the DUT
  always @(negedge clk) begin
    if (cmpOn) begin
      checkOutput("req", 32'(req), 32'(expReq));
      checkOutput("stallreq", 32'(stallreq), 32'(expStall));
      checkOutput("exc_adel", 32'(exc_adel), 32'(en & ld & misal(ls_type, vaddr[1:0])));
      checkOutput("exc_ades", 32'(exc_ades), 32'(en & st & misal(ls_type, vaddr[1:0])));
      checkOutput("m_vaddr", m_vaddr, expMVaddr);
      checkOutput("m_rdata", m_rdata, expMRdata);
      if (expReq) begin
        checkOutput("addr", addr, expAddr);
        checkOutput("wr", 32'(wr), 32'(expWr));
        checkOutput("size", 32'(size), 32'(expSize));
        checkOutput("wstrb", 32'(wstrb), 32'(expStrb));
        if (expWr) begin
          checkOutput("wdata", wdata, expWdata);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int n);
    expReq = 1'b0;
    expStall = 1'b1;
    for (int i = 0; i < n; i++) begin
      data_ok = 1'b0;
      rdata = $urandom;
      tick();
    end
    data_ok = 1'b1;
    rdata = $urandom;
    tick();
    data_ok = 1'b0;
    expStall = 1'b0;
  endtask

  // flushMode: 0 none, 1 ADDR w/o addr_ok, 2 ADDR with addr_ok, 3 DATA w/o data_ok, 4 DATA with data_ok, 5 DONE
  task automatic applyStimulus(input bit isLoad, input logic [2:0] ty, input logic [31:0] va,
                               input logic [31:0] rt, input logic [31:0] rd, input int aWait,
                               input int dWait, input int flushMode, input int drWait, input int doneHold);
    logic [3:0]  strb;
    logic [31:0] wd;
    logic [1:0]  sz;
    busModel(ty, va[1:0], rt, strb, wd, sz);
    en = 1'b1;
    ld = isLoad;
    st = !isLoad;
    ls_type = ty;
    vaddr = va;
    st_data = rt;
    flush = 1'b0;
    adv = 1'b0;
    addr_ok = 1'b0;
    data_ok = 1'b0;
    rdata = $urandom;
    expReq = 1'b0;
    expStall = 1'b1;
    tick();
    expMVaddr = va;
    expAddr = {va[31:2], 2'b00};
    expWr = !isLoad;
    expSize = sz;
    expStrb = isLoad ? 4'b0000 : strb;
    expWdata = wd;
    expReq = 1'b1;
    for (int i = 0; i < aWait; i++) begin
      tick();
    end
    if (flushMode == 1) begin
      flush = 1'b1;
      tick();
      flush = 1'b0;
      en = 1'b0;
      expReq = 1'b0;
      expStall = 1'b0;
      return;
    end
    addr_ok = 1'b1;
    flush = (flushMode == 2);
    tick();
    addr_ok = 1'b0;
    flush = 1'b0;
    expReq = 1'b0;
    if (flushMode == 2) begin
      en = 1'b0;
      drain(drWait);
      return;
    end
    for (int i = 0; i < dWait; i++) begin
      rdata = $urandom;
      tick();
    end
    if (flushMode == 3) begin
      flush = 1'b1;
      tick();
      flush = 1'b0;
      en = 1'b0;
      drain(drWait);
      return;
    end
    if (flushMode == 4) begin
      flush = 1'b1;
      data_ok = 1'b1;
      rdata = rd;
      tick();
      flush = 1'b0;
      data_ok = 1'b0;
      en = 1'b0;
      expStall = 1'b0;
      return;
    end
    data_ok = 1'b1;
    rdata = rd;
    tick();
    data_ok = 1'b0;
    rdata = $urandom;
    expStall = 1'b0;
    if (isLoad) begin
      expMRdata = rd;
    end
    for (int i = 0; i < doneHold; i++) begin
      data_ok = 1'($urandom);
      rdata = $urandom;
      tick();
    end
    data_ok = 1'b0;
    if (flushMode == 5) begin
      flush = 1'b1;
    end else begin
      adv = 1'b1;
    end
    tick();
    adv = 1'b0;
    flush = 1'b0;
    en = 1'b0;
    ld = 1'b0;
    st = 1'b0;
  endtask

  task automatic misalignedAccess(input bit isLoad, input logic [2:0] ty, input logic [31:0] va);
    en = 1'b1;
    ld = isLoad;
    st = !isLoad;
    ls_type = ty;
    vaddr = va;
    st_data = $urandom;
    flush = 1'b0;
    adv = 1'b0;
    addr_ok = 1'b0;
    data_ok = 1'b0;
    expReq = 1'b0;
    expStall = 1'b0;
    tick();
    en = 1'b0;
  endtask

  // Non-memory, disabled, or flushed instructions in IDLE; stray data_ok must be ignored
  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) begin
      int kind;
      kind = $urandom_range(0, 2);
      en = (kind != 1);
      ld = 1'b0;
      st = 1'b0;
      flush = (kind == 2);
      if (kind != 0) begin
        if ($urandom_range(0, 1) == 1) ld = 1'b1;
        else st = 1'b1;
      end
      ls_type = 3'($urandom);
      vaddr = $urandom;
      st_data = $urandom;
      adv = 1'($urandom);
      addr_ok = 1'b0;
      data_ok = 1'($urandom);
      rdata = $urandom;
      expReq = 1'b0;
      expStall = 1'b0;
      tick();
    end
    en = 1'b0;
    ld = 1'b0;
    st = 1'b0;
    flush = 1'b0;
    data_ok = 1'b0;
  endtask

  initial begin
    logic [3:0]  pStrb;
    logic [31:0] pData;
    logic [1:0]  pSize;
    passCount = 0;
    checkCount = 0;
    cmpOn = 1'b0;
    resetn = 1'b0;
    en = 1'b0;
    ld = 1'b0;
    st = 1'b0;
    ls_type = 3'd0;
    vaddr = 32'd0;
    st_data = 32'd0;
    adv = 1'b0;
    flush = 1'b0;
    addr_ok = 1'b0;
    data_ok = 1'b0;
    rdata = 32'd0;
    expReq = 1'b0;
    expStall = 1'b0;
    expWr = 1'b0;
    expSize = 2'd0;
    expAddr = 32'd0;
    expStrb = 4'd0;
    expWdata = 32'd0;
    expMVaddr = 32'd0;
    expMRdata = 32'd0;

    busModel(3'd0, 2'd3, 32'h12345678, pStrb, pData, pSize);
    checkOutput("model SB strb", 32'(pStrb), 32'h8);
    checkOutput("model SB data", pData, 32'h78787878);
    busModel(3'd4, 2'd1, 32'hAABBCCDD, pStrb, pData, pSize);
    checkOutput("model SWR1 strb", 32'(pStrb), 32'hE);
    checkOutput("model SWR1 data", pData, 32'hBBCCDD00);
    busModel(3'd3, 2'd2, 32'hAABBCCDD, pStrb, pData, pSize);
    checkOutput("model SWL2 strb", 32'(pStrb), 32'h7);
    checkOutput("model SWL2 data", pData, 32'h00AABBCC);

    #12;
    checkOutput("reset req", 32'(req), 32'd0);
    checkOutput("reset wr", 32'(wr), 32'd0);
    checkOutput("reset size", 32'(size), 32'd0);
    checkOutput("reset addr", addr, 32'd0);
    checkOutput("reset wstrb", 32'(wstrb), 32'd0);
    checkOutput("reset wdata", wdata, 32'd0);
    checkOutput("reset m_vaddr", m_vaddr, 32'd0);
    checkOutput("reset m_rdata", m_rdata, 32'd0);
    checkOutput("reset stallreq", 32'(stallreq), 32'd0);
    @(posedge clk);
    #1;
    resetn = 1'b1;
    cmpOn = 1'b1;
    idleCycles(2);

    $display("[TB] directed: LW, SB, SWL/SWR sweep, address errors, flushes");
    applyStimulus(1'b1, 3'd2, 32'h0000_1000, 32'h0, 32'hDEADBEEF, 0, 1, 0, 0, 1);
    checkOutput("LW m_rdata", m_rdata, 32'hDEADBEEF);
    checkOutput("LW m_vaddr", m_vaddr, 32'h0000_1000);
    applyStimulus(1'b0, 3'd0, 32'h0000_2003, 32'h12345678, 32'h0, 0, 0, 0, 0, 0);
    checkOutput("SB m_rdata kept", m_rdata, 32'hDEADBEEF);
    for (int a = 0; a < 4; a++) begin
      applyStimulus(1'b0, 3'd3, 32'h0000_6000 + 32'(a), 32'hAABBCCDD, 32'h0, a % 2, 0, 0, 0, 0);
      applyStimulus(1'b0, 3'd4, 32'h0000_6100 + 32'(a), 32'hAABBCCDD, 32'h0, 0, a % 2, 0, 0, 0);
    end
    misalignedAccess(1'b1, 3'd1, 32'h0000_3001);
    misalignedAccess(1'b0, 3'd2, 32'h0000_3002);
    en = 1'b1;
    ld = 1'b1;
    st = 1'b0;
    ls_type = 3'd1;
    vaddr = 32'h0000_3001;
    #1;
    checkOutput("LH exc_adel", 32'(exc_adel), 32'd1);
    checkOutput("LH stallreq", 32'(stallreq), 32'd0);
    ld = 1'b0;
    st = 1'b1;
    ls_type = 3'd2;
    vaddr = 32'h0000_3002;
    #1;
    checkOutput("SW exc_ades", 32'(exc_ades), 32'd1);
    en = 1'b0;
    st = 1'b0;
    tick();
    applyStimulus(1'b1, 3'd2, 32'h0000_7000, 32'h0, 32'h11112222, 1, 0, 3, 2, 0);
    checkOutput("flush DATA m_rdata kept", m_rdata, 32'hDEADBEEF);
    applyStimulus(1'b1, 3'd2, 32'h0000_7100, 32'h0, 32'h33334444, 1, 0, 1, 0, 0);
    idleCycles(1);
    applyStimulus(1'b0, 3'd1, 32'h0000_7202, 32'h0000BEEF, 32'h0, 0, 1, 2, 1, 0);
    applyStimulus(1'b1, 3'd0, 32'h0000_7303, 32'h0, 32'h55556666, 0, 0, 4, 0, 0);
    applyStimulus(1'b1, 3'd2, 32'h0000_7400, 32'h0, 32'h77778888, 0, 0, 5, 0, 1);
    checkOutput("flush DONE m_rdata", m_rdata, 32'h77778888);

    $display("[TB] directed: reset while in DATA");
    en = 1'b1;
    ld = 1'b1;
    st = 1'b0;
    ls_type = 3'd2;
    vaddr = 32'h0000_4000;
    expReq = 1'b0;
    expStall = 1'b1;
    tick();
    expMVaddr = 32'h0000_4000;
    expAddr = 32'h0000_4000;
    expWr = 1'b0;
    expSize = 2'd2;
    expStrb = 4'd0;
    expReq = 1'b1;
    addr_ok = 1'b1;
    tick();
    addr_ok = 1'b0;
    expReq = 1'b0;
    tick();
    cmpOn = 1'b0;
    resetn = 1'b0;
    en = 1'b0;
    ld = 1'b0;
    #1;
    checkOutput("rst req", 32'(req), 32'd0);
    checkOutput("rst addr", addr, 32'd0);
    checkOutput("rst size", 32'(size), 32'd0);
    checkOutput("rst m_vaddr", m_vaddr, 32'd0);
    checkOutput("rst m_rdata", m_rdata, 32'd0);
    checkOutput("rst stallreq", 32'(stallreq), 32'd0);
    tick();
    resetn = 1'b1;
    expMVaddr = 32'd0;
    expMRdata = 32'd0;
    expReq = 1'b0;
    expStall = 1'b0;
    cmpOn = 1'b1;
    idleCycles(1);
    applyStimulus(1'b1, 3'd2, 32'h0000_5004, 32'h0, 32'h0BADF00D, 0, 0, 0, 0, 0);
    checkOutput("post-reset LW m_rdata", m_rdata, 32'h0BADF00D);

    $display("[TB] random transactions");
    for (int n = 0; n < 200; n++) begin
      bit          isLoad;
      logic [2:0]  ty;
      logic [31:0] va;
      int          r;
      int          mode;
      isLoad = 1'($urandom);
      ty = 3'($urandom);
      va = $urandom;
      if (misal(ty, va[1:0])) begin
        misalignedAccess(isLoad, ty, va);
      end else begin
        r = $urandom_range(0, 9);
        mode = (r < 5) ? 0 : r - 4;
        applyStimulus(isLoad, ty, va, $urandom, $urandom, $urandom_range(0, 3), $urandom_range(0, 3),
                      mode, $urandom_range(0, 3), $urandom_range(0, 2));
      end
      idleCycles($urandom_range(0, 2));
    end
    idleCycles(2);

    cmpOn = 1'b0;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
